// File: rtl/grf_bypass.sv
// General register file: two async read ports, one sync write port with same-cycle
// write-to-read bypass, plus a per-register pending scoreboard for decode stalls.
module grf_bypass #(
  parameter int unsigned DW       = 32,
  parameter int unsigned AW       = 5,
  parameter int unsigned ZERO_REG = 1,
  parameter int unsigned TRACE    = 1
) (
  input  logic          clk,
  input  logic          rst,
  input  logic [31:0]   pc,
  input  logic [AW-1:0] A1,
  input  logic [AW-1:0] A2,
  output logic [DW-1:0] RD1,
  output logic [DW-1:0] RD2,
  output logic          busy1,
  output logic          busy2,
  input  logic          RFWr,
  input  logic [AW-1:0] A3,
  input  logic [DW-1:0] WD,
  input  logic          iss_en,
  input  logic [AW-1:0] iss_addr,
  output logic          pend_any
);

  localparam int unsigned DEPTH = 2 ** AW;
  localparam logic        ZR    = (ZERO_REG != 0);

  logic [DW-1:0]    regs_q [DEPTH];
  logic [DEPTH-1:0] pend_q;
  logic [DEPTH-1:0] pend_d;

  logic wr_acc_c;
  logic iss_acc_c;

  assign wr_acc_c  = RFWr && !rst && ((A3 != '0) || !ZR);
  assign iss_acc_c = iss_en && !rst && ((iss_addr != '0) || !ZR);

  // Writeback clears the bit first so a same-cycle issue (newer producer) wins.
  always_comb begin
    pend_d = pend_q;
    if (wr_acc_c)  pend_d[A3]       = 1'b0;
    if (iss_acc_c) pend_d[iss_addr] = 1'b1;
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      for (int i = 0; i < int'(DEPTH); i++) regs_q[i] <= '0;
      pend_q <= '0;
    end else begin
      if (wr_acc_c) begin
        regs_q[A3] <= WD;
        if (TRACE != 0) $display("@%h: $%d <= %h", pc, A3, WD);
      end
      pend_q <= pend_d;
    end
  end

  // Read port 1: bypass, then hardwired zero, then storage.
  always_comb begin
    RD1 = regs_q[A1];
    if (ZR && (A1 == '0)) RD1 = '0;
    if (wr_acc_c && (A3 == A1)) RD1 = WD;
  end

  always_comb begin
    RD2 = regs_q[A2];
    if (ZR && (A2 == '0)) RD2 = '0;
    if (wr_acc_c && (A3 == A2)) RD2 = WD;
  end

  // A writeback landing this cycle already resolves the hazard.
  always_comb begin
    busy1 = pend_q[A1] && !(wr_acc_c && (A3 == A1));
    if (ZR && (A1 == '0)) busy1 = 1'b0;
  end

  always_comb begin
    busy2 = pend_q[A2] && !(wr_acc_c && (A3 == A2));
    if (ZR && (A2 == '0)) busy2 = 1'b0;
  end

  assign pend_any = |pend_q;

endmodule

// File: tb/tb_grf_bypass.sv
// Directed bench for grf_bypass: reset, bypass, zero register, scoreboard and reset override.
module tb_grf_bypass;

  logic        clk = 1'b0;
  logic        rst;
  logic [31:0] pc;
  logic [4:0]  A1, A2, A3, iss_addr;
  logic [31:0] RD1, RD2, WD;
  logic        busy1, busy2, RFWr, iss_en, pend_any;

  int tests  = 0;
  int failed = 0;

  grf_bypass #(.DW(32), .AW(5), .ZERO_REG(1), .TRACE(1)) dut (
    .clk      (clk),
    .rst      (rst),
    .pc       (pc),
    .A1       (A1),
    .A2       (A2),
    .RD1      (RD1),
    .RD2      (RD2),
    .busy1    (busy1),
    .busy2    (busy2),
    .RFWr     (RFWr),
    .A3       (A3),
    .WD       (WD),
    .iss_en   (iss_en),
    .iss_addr (iss_addr),
    .pend_any (pend_any)
  );

  always #5 clk = ~clk;

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    tests++;
    assert (obs === exp) else begin
      failed++;
      $error("FAIL %s: observed %h expected %h", tag, obs, exp);
    end
  endtask

  task automatic idle();
    RFWr = 1'b0; iss_en = 1'b0; A3 = '0; WD = '0; iss_addr = '0;
  endtask

  initial begin
    rst = 1'b1; pc = 32'h0000_3000; A1 = '0; A2 = '0;
    idle();
    @(negedge clk);

    // Reset state
    rst = 1'b0; A1 = 5'd3; A2 = 5'd31;
    #1;
    check("rst_rd1", RD1, 32'h0);
    check("rst_rd2", RD2, 32'h0);
    check("rst_busy1", 32'(busy1), 32'h0);
    check("rst_busy2", 32'(busy2), 32'h0);
    check("rst_pend_any", 32'(pend_any), 32'h0);

    // Write with same-cycle bypass
    @(negedge clk);
    pc = 32'h0000_3004; RFWr = 1'b1; A3 = 5'd5; WD = 32'hDEAD_BEEF; A1 = 5'd5; A2 = 5'd6;
    #1;
    check("byp_rd1", RD1, 32'hDEAD_BEEF);
    check("byp_rd2_other", RD2, 32'h0);
    @(negedge clk);
    idle();
    #1;
    check("stored_rd1", RD1, 32'hDEAD_BEEF);

    // Zero register ignores writes and issues
    @(negedge clk);
    RFWr = 1'b1; A3 = 5'd0; WD = 32'h0000_1234; iss_en = 1'b1; iss_addr = 5'd0; A1 = 5'd0;
    #1;
    check("zero_rd1_byp", RD1, 32'h0);
    check("zero_busy1", 32'(busy1), 32'h0);
    @(negedge clk);
    idle();
    #1;
    check("zero_rd1_after", RD1, 32'h0);
    check("zero_pend_any", 32'(pend_any), 32'h0);

    // Scoreboard: issue r7, write it back three cycles later
    @(negedge clk);
    iss_en = 1'b1; iss_addr = 5'd7; A1 = 5'd7;
    #1;
    check("sb_issue_not_visible", 32'(busy1), 32'h0);
    @(negedge clk);
    idle();
    #1;
    check("sb_busy1_set", 32'(busy1), 32'h1);
    check("sb_pend_any_set", 32'(pend_any), 32'h1);
    @(negedge clk);
    @(negedge clk);
    pc = 32'h0000_3010; RFWr = 1'b1; A3 = 5'd7; WD = 32'h0000_0077;
    #1;
    check("sb_busy1_masked", 32'(busy1), 32'h0);
    check("sb_rd1_byp", RD1, 32'h0000_0077);
    check("sb_pend_any_unmasked", 32'(pend_any), 32'h1);
    @(negedge clk);
    idle();
    #1;
    check("sb_busy1_clear", 32'(busy1), 32'h0);
    check("sb_pend_any_clear", 32'(pend_any), 32'h0);

    // Simultaneous issue and write: pending survives, data updates
    @(negedge clk);
    iss_en = 1'b1; iss_addr = 5'd9; A2 = 5'd9;
    @(negedge clk);
    pc = 32'h0000_3020; RFWr = 1'b1; A3 = 5'd9; WD = 32'd55;
    #1;
    check("sim_busy2_masked", 32'(busy2), 32'h0);
    check("sim_rd2_byp", RD2, 32'd55);
    @(negedge clk);
    idle();
    #1;
    check("sim_busy2_kept", 32'(busy2), 32'h1);
    check("sim_rd2_stored", RD2, 32'd55);
    RFWr = 1'b1; A3 = 5'd9; WD = 32'd56;
    @(negedge clk);
    idle();
    #1;
    check("sim_pend_cleared", 32'(pend_any), 32'h0);

    // Reset mid-operation overrides write, issue and bypass
    iss_en = 1'b1; iss_addr = 5'd4;
    @(negedge clk);
    idle();
    rst = 1'b1; RFWr = 1'b1; A3 = 5'd4; WD = 32'h0000_00AA; iss_en = 1'b1; iss_addr = 5'd12;
    A1 = 5'd4; A2 = 5'd5;
    #1;
    check("mid_rd1_no_byp", RD1, 32'h0);
    check("mid_rd2_stored", RD2, 32'hDEAD_BEEF);
    check("mid_busy1_pending", 32'(busy1), 32'h1);
    @(negedge clk);
    rst = 1'b0;
    idle();
    #1;
    check("mid_rd1_after", RD1, 32'h0);
    check("mid_rd2_after", RD2, 32'h0);
    check("mid_busy1_after", 32'(busy1), 32'h0);
    check("mid_pend_any_after", 32'(pend_any), 32'h0);

    // Top address, both ports bypassing the same register
    @(negedge clk);
    pc = 32'h0000_3040; RFWr = 1'b1; A3 = 5'd31; WD = 32'hA5A5_5A5A; A1 = 5'd31; A2 = 5'd31;
    #1;
    check("top_rd1_byp", RD1, 32'hA5A5_5A5A);
    check("top_rd2_byp", RD2, 32'hA5A5_5A5A);
    @(negedge clk);
    idle();
    A2 = 5'd30;
    #1;
    check("top_rd1_stored", RD1, 32'hA5A5_5A5A);
    check("top_rd2_neighbour", RD2, 32'h0);

    $display("[TB] %0d tests run, %0d failed", tests, failed);
    $finish;
  end

endmodule

// File: doc/grf_bypass.md
Name: grf_bypass

Overview:
- Parametrised general register file for the pipelined CPU: two asynchronous read ports, one synchronous write port, same-cycle write-to-read bypass.
- Adds a per-register pending (scoreboard) bit, set when an instruction that will write a register issues and cleared on its writeback. Decode uses the pending bits for stall decisions.
- Emits the standard writeback trace line for the grading testbench.

Parameters:
- DW, 32, data width of each register.
- AW, 5, address width; depth is 2**AW.
- ZERO_REG, 1: 1 = register 0 reads as 0, ignores writes and is never pending; 0 = register 0 is an ordinary register.
- TRACE, 1: 1 = print the trace line on every accepted write; 0 = silent.

Ports:
- clk  in  1  clock; all state updates on posedge.
- rst  in  1  synchronous active-high reset.
- pc  in  32  PC of the writing instruction; used for the trace only.
- A1  in  AW  read address, port 1.
- A2  in  AW  read address, port 2.
- RD1  out  DW  read data, port 1.
- RD2  out  DW  read data, port 2.
- busy1  out  1  pending bit for A1.
- busy2  out  1  pending bit for A2.
- RFWr  in  1  write enable.
- A3  in  AW  write address.
- WD  in  DW  write data.
- iss_en  in  1  issue strobe: mark iss_addr pending.
- iss_addr  in  AW  destination register of the issuing instruction.
- pend_any  out  1  OR of all pending bits.

Behaviour:
- Storage: 2**AW x DW registers plus a 2**AW-bit pending vector.
- Reset (rst=1 at posedge): all registers <= 0 and all pending bits <= 0. Writes and issues in that cycle are ignored; no trace is printed. After reset: RD1=RD2=0, busy1=busy2=0, pend_any=0.
- Write accepted when RFWr=1, rst=0, and (A3!=0 or ZERO_REG=0).
  - At posedge: reg[A3] <= WD and pending[A3] <= 0, unless the issue rule below re-sets it.
  - If TRACE=1: print "@%h: $%d <= %h" with pc, A3, WD in the same posedge block.
- Issue accepted when iss_en=1, rst=0, and (iss_addr!=0 or ZERO_REG=0).
  - At posedge: pending[iss_addr] <= 1.
  - Issue and write to the same address in the same cycle: pending ends at 1, because the newer producer wins. Register data is still updated.
- Reads are combinational, with zero added latency.
  - RDn = WD if (write accepted and A3==An).
  - Otherwise RDn = 0 if (ZERO_REG=1 and An==0).
  - Otherwise RDn = reg[An].
  - Bypass applies to both ports independently; A1==A2 is legal.
- Busy outputs are combinational.
  - busyn = pending[An] AND NOT (write accepted and A3==An).
  - busyn is forced to 0 when ZERO_REG=1 and An==0.
  - A same-cycle issue is not visible on busyn until the next cycle.
  - pend_any uses the registered pending vector only, with no same-cycle masking.
- Writing a register that is not pending is legal: data updates, pending stays 0.
- Issuing an already-pending register is legal: pending stays 1. There is no counter; one writeback clears it.
- Reset asserted mid-operation overrides any simultaneous write or issue. Bypass paths are also inhibited while rst=1: RDn = stored value, which is 0 after the first reset edge.
- Address width: all address compares use the full AW bits with no wrap. Depth is exactly 2**AW.

Test Plan:
- Reset then read: rst=1 for one edge, then A1=3, A2=31 -> RD1=0, RD2=0, busy1=busy2=0, pend_any=0.
- Write then bypass: RFWr=1, A3=5, WD=32'hDEADBEEF, A1=5 in the same cycle -> RD1=DEADBEEF before the edge. After the edge with RFWr=0 -> RD1=DEADBEEF; trace line shows "$ 5 <= deadbeef".
- Zero register: ZERO_REG=1, RFWr=1, A3=0, WD=1234, iss_en=1, iss_addr=0 -> no trace printed; A1=0 gives RD1=0 and busy1=0; pend_any=0.
- Scoreboard: iss_en=1, iss_addr=7 at edge N -> busy1=1 for A1=7 from N+1. RFWr=1, A3=7 at N+3 -> busy1=0 combinationally in that cycle, pending=0 after the edge, pend_any=0.
- Simultaneous issue and write: pending[9]=1, then iss_en=1, iss_addr=9, RFWr=1, A3=9, WD=55 at the same edge -> reg[9]=55 and busy for A2=9 stays 1 next cycle.
- Reset mid-operation: pending[4]=1, rst=1 with RFWr=1, A3=4, WD=AA -> RD for A1=4 reads 0 (no bypass), no trace; after the edge reg[4]=0, pending=0.
